rib_arbiter_nm: RTL and testbench

Parametrised N-master to 1-slave RIB arbiter with in-order response routing. It replaces the fixed ibus/dbus pairing at the core top, letting IFU, LSU, and future masters such as a DMA or debug port share one RIB slave port. Up to MAX_OUTSTANDING granted requests may be in flight. Responses are returned in grant order to the master that issued each request.

---
 rtl/rib_pkg.sv | 26 ++
 rtl/rib_arb_ord_fifo.sv | 55 +++++
 rtl/rib_arbiter_nm.sv | 167 ++++++++++++++++
 tb/tb_rib_arbiter_nm.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_pkg.sv
// Shared RIB definitions: bus widths, the master-index type and a
// one-hot-to-index helper used by the arbiter.
package rib_pkg;

    localparam int RIB_ADDR_W      = 32;
    localparam int RIB_DATA_W      = 32;
    localparam int RIB_MASK_W      = RIB_DATA_W / 8;

    // Largest supported master count; the index type is sized for it and
    // narrowed to clog2(NUM_MASTERS) bits inside the arbiter.
    localparam int RIB_MAX_MASTERS = 8;
    localparam int RIB_MIDX_W      = $clog2(RIB_MAX_MASTERS);

    typedef logic [RIB_MIDX_W-1:0] rib_midx_t;

    // Encode a one-hot (or zero) vector into the index of its set bit.
    function automatic rib_midx_t rib_oh2idx(input logic [RIB_MAX_MASTERS-1:0] oh);
        rib_midx_t idx;
        idx = '0;
        for (int k = 0; k < RIB_MAX_MASTERS; k++) begin
            if (oh[k]) idx = idx | rib_midx_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rib_arb_ord_fifo.sv
// Grant-order FIFO: remembers which master owns each in-flight request so
// responses are routed back in grant order. Pointers wrap modulo DEPTH.
module rib_arb_ord_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_idx,
    input  logic             pop,
    output logic [W-1:0]     head_idx,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_idx = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop together keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/rib_arbiter_nm.sv
// N-master to 1-slave RIB arbiter with in-order response routing.
// Configuration macro RIB_ARB_RR_EN: defined selects round-robin
// arbitration; undefined selects fixed priority (lowest index wins).
// Valid/ready: a request transfers in a cycle where o_s_req & i_s_gnt
// (grant is passed through to the winner in that same cycle); a response
// transfers in a cycle where i_s_rsp & o_s_rdy.
module rib_arbiter_nm
    import rib_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_W          = RIB_ADDR_W,
    parameter int DATA_W          = RIB_DATA_W,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
    input  logic [NUM_MASTERS-1:0]        i_m_wrcs,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] i_m_mask,
    input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wdata,
    input  logic [NUM_MASTERS-1:0]        i_m_req,
    output logic [NUM_MASTERS-1:0]        o_m_gnt,
    output logic [NUM_MASTERS*DATA_W-1:0] o_m_rdata,
    output logic [NUM_MASTERS-1:0]        o_m_rsp,
    input  logic [NUM_MASTERS-1:0]        i_m_rdy,
    output logic [ADDR_W-1:0]             o_s_addr,
    output logic                          o_s_wrcs,
    output logic [DATA_W/8-1:0]           o_s_mask,
    output logic [DATA_W-1:0]             o_s_wdata,
    output logic                          o_s_req,
    input  logic                          i_s_gnt,
    input  logic [DATA_W-1:0]             i_s_rdata,
    input  logic                          i_s_rsp,
    output logic                          o_s_rdy,
    output logic                          o_err_unexp_rsp
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    logic             lock_vld;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_found;
    logic [IDX_W-1:0] win_idx;
    logic             win_req;
    logic             gnt_fire;
    logic             rsp_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    logic [IDX_W-1:0] head_idx;

`ifdef RIB_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (int'(rr_ptr) + k >= NUM_MASTERS) cand = IDX_W'(int'(rr_ptr) + k - NUM_MASTERS);
            else                                 cand = IDX_W'(int'(rr_ptr) + k);
            if (!arb_found && i_m_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Pointer moves past the master just granted.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)       rr_ptr <= '0;
        else if (gnt_fire) rr_ptr <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
`else
    logic [RIB_MAX_MASTERS-1:0] req_ext;
    logic [RIB_MAX_MASTERS-1:0] low_oh;

    // Fixed priority: isolate the lowest set request bit.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_MASTERS-1:0] = i_m_req;
        low_oh                 = req_ext & (~req_ext + RIB_MAX_MASTERS'(1));
        arb_found              = |i_m_req;
        arb_idx                = IDX_W'(rib_oh2idx(low_oh));
    end
`endif

    // A held lock overrides arbitration until the slave grants.
    always_comb begin
        if (lock_vld) begin
            win_idx = lock_idx;
            win_req = i_m_req[lock_idx];
        end else begin
            win_idx = arb_idx;
            win_req = arb_found;
        end
    end

    assign o_s_req   = win_req & ~fifo_full;
    assign gnt_fire  = o_s_req & i_s_gnt;
    assign o_m_gnt   = gnt_fire ? (NUM_MASTERS'(1) << win_idx) : '0;

    // Steer the winner's request payload to the slave; idle bus reads zero.
    always_comb begin
        o_s_addr  = '0;
        o_s_wrcs  = 1'b0;
        o_s_mask  = '0;
        o_s_wdata = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_req && win_idx == IDX_W'(k)) begin
                o_s_addr  = i_m_addr[k*ADDR_W +: ADDR_W];
                o_s_wrcs  = i_m_wrcs[k];
                o_s_mask  = i_m_mask[k*MASK_W +: MASK_W];
                o_s_wdata = i_m_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Lock captures a presented-but-ungranted winner; released on grant or
    // when the locked master withdraws.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (gnt_fire) begin
            lock_vld <= 1'b0;
        end else if (o_s_req) begin
            lock_vld <= 1'b1;
            lock_idx <= win_idx;
        end else if (lock_vld && !i_m_req[lock_idx]) begin
            lock_vld <= 1'b0;
        end
    end

    rib_arb_ord_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rstn),
        .push     (gnt_fire),
        .push_idx (win_idx),
        .pop      (rsp_pop),
        .head_idx (head_idx),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign o_s_rdy   = ~fifo_empty & i_m_rdy[head_idx];
    assign o_m_rsp   = (i_s_rsp & ~fifo_empty) ? (NUM_MASTERS'(1) << head_idx) : '0;
    assign rsp_pop   = i_s_rsp & o_s_rdy;
    assign o_m_rdata = {NUM_MASTERS{i_s_rdata}};

    // Sticky flag for a slave response with nothing outstanding.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                          o_err_unexp_rsp <= 1'b0;
        else if (i_s_rsp && fifo_cnt == '0)   o_err_unexp_rsp <= 1'b1;
    end

endmodule

// File: tb/tb_rib_arbiter_nm.sv
// Directed bench for rib_arbiter_nm (2 masters, 2 outstanding).
module tb_rib_arbiter_nm;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int MO = 2;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic [NM*AW-1:0]  i_m_addr;
    logic [NM-1:0]     i_m_wrcs;
    logic [NM*MW-1:0]  i_m_mask;
    logic [NM*DW-1:0]  i_m_wdata;
    logic [NM-1:0]     i_m_req;
    logic [NM-1:0]     o_m_gnt;
    logic [NM*DW-1:0]  o_m_rdata;
    logic [NM-1:0]     o_m_rsp;
    logic [NM-1:0]     i_m_rdy;
    logic [AW-1:0]     o_s_addr;
    logic              o_s_wrcs;
    logic [MW-1:0]     o_s_mask;
    logic [DW-1:0]     o_s_wdata;
    logic              o_s_req;
    logic              i_s_gnt;
    logic [DW-1:0]     i_s_rdata;
    logic              i_s_rsp;
    logic              o_s_rdy;
    logic              o_err_unexp_rsp;

    int n_pass  = 0;
    int n_total = 0;

    rib_arbiter_nm #(
        .NUM_MASTERS     (NM),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_m_addr        (i_m_addr),
        .i_m_wrcs        (i_m_wrcs),
        .i_m_mask        (i_m_mask),
        .i_m_wdata       (i_m_wdata),
        .i_m_req         (i_m_req),
        .o_m_gnt         (o_m_gnt),
        .o_m_rdata       (o_m_rdata),
        .o_m_rsp         (o_m_rsp),
        .i_m_rdy         (i_m_rdy),
        .o_s_addr        (o_s_addr),
        .o_s_wrcs        (o_s_wrcs),
        .o_s_mask        (o_s_mask),
        .o_s_wdata       (o_s_wdata),
        .o_s_req         (o_s_req),
        .i_s_gnt         (i_s_gnt),
        .i_s_rdata       (i_s_rdata),
        .i_s_rsp         (i_s_rsp),
        .o_s_rdy         (o_s_rdy),
        .o_err_unexp_rsp (o_err_unexp_rsp)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // A locked master must keep requesting until granted.
    always @(negedge i_clk) begin
        if (i_rstn && dut.lock_vld && !i_m_req[dut.lock_idx]) begin
            n_total++;
            $display("FAIL lock_drop: locked master %0d dropped req", dut.lock_idx);
        end
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Driver helpers
    task automatic idle_inputs();
        i_m_addr  = '0;
        i_m_wrcs  = '0;
        i_m_mask  = '0;
        i_m_wdata = '0;
        i_m_req   = '0;
        i_m_rdy   = '0;
        i_s_gnt   = 1'b0;
        i_s_rdata = '0;
        i_s_rsp   = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rstn = 1'b0;
        #3;
        n_total++; if (o_s_req !== 1'b0) $display("FAIL rst_s_req: got %b want 0", o_s_req); else n_pass++;
        n_total++; if (o_m_gnt !== 2'b00) $display("FAIL rst_m_gnt: got %b want 00", o_m_gnt); else n_pass++;
        n_total++; if (o_m_rsp !== 2'b00) $display("FAIL rst_m_rsp: got %b want 00", o_m_rsp); else n_pass++;
        n_total++; if (o_s_rdy !== 1'b0) $display("FAIL rst_s_rdy: got %b want 0", o_s_rdy); else n_pass++;
        n_total++; if (o_err_unexp_rsp !== 1'b0) $display("FAIL rst_err: got %b want 0", o_err_unexp_rsp); else n_pass++;
        n_total++; if (o_s_addr !== 32'h0) $display("FAIL rst_s_addr: got %h want 0", o_s_addr); else n_pass++;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL rst_cnt: got %0d want 0", dut.fifo_cnt); else n_pass++;
        tick();
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic test_single();
        tick();
        i_m_addr[AW +: AW] = 32'h100;
        i_m_req  = 2'b10;
        i_s_gnt  = 1'b1;
        #1;
        n_total++; if (o_s_req !== 1'b1) $display("FAIL single_s_req: got %b want 1", o_s_req); else n_pass++;
        n_total++; if (o_s_addr !== 32'h100) $display("FAIL single_addr: got %h want 100", o_s_addr); else n_pass++;
        n_total++; if (o_s_wrcs !== 1'b0) $display("FAIL single_wrcs: got %b want 0", o_s_wrcs); else n_pass++;
        n_total++; if (o_m_gnt !== 2'b10) $display("FAIL single_gnt: got %b want 10", o_m_gnt); else n_pass++;
        tick();
        i_m_req = 2'b00;
        i_s_gnt = 1'b0;
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd1) $display("FAIL single_cnt1: got %0d want 1", dut.fifo_cnt); else n_pass++;
        tick();
        tick();
        i_s_rsp   = 1'b1;
        i_s_rdata = 32'hDEADBEEF;
        i_m_rdy   = 2'b11;
        #1;
        n_total++; if (o_m_rsp !== 2'b10) $display("FAIL single_rsp: got %b want 10", o_m_rsp); else n_pass++;
        n_total++; if (o_m_rdata[DW +: DW] !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h want deadbeef", o_m_rdata[DW +: DW]); else n_pass++;
        n_total++; if (o_s_rdy !== 1'b1) $display("FAIL single_s_rdy: got %b want 1", o_s_rdy); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL single_cnt0: got %0d want 0", dut.fifo_cnt); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [4];
`ifdef RIB_ARB_RR_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            i_m_addr  = {32'h20, 32'h10};
            i_m_req   = 2'b11;
            i_s_gnt   = 1'b1;
            i_m_rdy   = 2'b11;
            i_s_rsp   = (c > 0);
            i_s_rdata = 32'hC0DE0000 + c;
            #1;
            n_total++; if (o_m_gnt !== exp_g[c]) $display("FAIL cont_gnt%0d: got %b want %b", c, o_m_gnt, exp_g[c]); else n_pass++;
            if (c > 0) begin
                n_total++; if (o_m_rsp !== exp_g[c-1]) $display("FAIL cont_rsp%0d: got %b want %b", c, o_m_rsp, exp_g[c-1]); else n_pass++;
            end
        end
        tick();
        idle_inputs();
        i_s_rsp = 1'b1;
        i_m_rdy = 2'b11;
        #1;
        n_total++; if (o_m_rsp !== exp_g[3]) $display("FAIL cont_rsp_last: got %b want %b", o_m_rsp, exp_g[3]); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL cont_cnt0: got %0d want 0", dut.fifo_cnt); else n_pass++;
    endtask

    task automatic test_lock();
        for (int c = 0; c < 5; c++) begin
            tick();
            i_m_addr = {32'h200, 32'h300};
            i_m_req  = (c == 0) ? 2'b10 : 2'b11;
            i_s_gnt  = (c == 4);
            #1;
            n_total++; if (o_s_addr !== 32'h200) $display("FAIL lock_addr%0d: got %h want 200", c, o_s_addr); else n_pass++;
            n_total++; if (o_m_gnt !== ((c == 4) ? 2'b10 : 2'b00)) $display("FAIL lock_gnt%0d: got %b want %b", c, o_m_gnt, (c == 4) ? 2'b10 : 2'b00); else n_pass++;
        end
        tick();
        i_m_req = 2'b01;
        i_s_gnt = 1'b1;
        #1;
        n_total++; if (o_m_gnt !== 2'b01) $display("FAIL lock_next_gnt: got %b want 01", o_m_gnt); else n_pass++;
        n_total++; if (o_s_addr !== 32'h300) $display("FAIL lock_next_addr: got %h want 300", o_s_addr); else n_pass++;
        tick();
        idle_inputs();
        i_s_rsp = 1'b1;
        i_m_rdy = 2'b11;
        #1;
        n_total++; if (o_m_rsp !== 2'b10) $display("FAIL lock_rsp_a: got %b want 10", o_m_rsp); else n_pass++;
        tick();
        #1;
        n_total++; if (o_m_rsp !== 2'b01) $display("FAIL lock_rsp_b: got %b want 01", o_m_rsp); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL lock_cnt0: got %0d want 0", dut.fifo_cnt); else n_pass++;
    endtask

    task automatic test_full();
        for (int c = 0; c < 2; c++) begin
            tick();
            i_m_addr[0 +: AW] = 32'h400;
            i_m_req = 2'b01;
            i_s_gnt = 1'b1;
            #1;
            n_total++; if (o_m_gnt !== 2'b01) $display("FAIL full_fill%0d: got %b want 01", c, o_m_gnt); else n_pass++;
        end
        tick();
        #1;
        n_total++; if (o_s_req !== 1'b0) $display("FAIL full_s_req: got %b want 0", o_s_req); else n_pass++;
        n_total++; if (o_m_gnt !== 2'b00) $display("FAIL full_gnt: got %b want 00", o_m_gnt); else n_pass++;
        n_total++; if (dut.fifo_cnt !== 2'd2) $display("FAIL full_cnt: got %0d want 2", dut.fifo_cnt); else n_pass++;
        tick();
        i_s_rsp = 1'b1;
        i_m_rdy = 2'b11;
        #1;
        n_total++; if (o_s_req !== 1'b0) $display("FAIL full_pop_s_req: got %b want 0", o_s_req); else n_pass++;
        n_total++; if (o_m_gnt !== 2'b00) $display("FAIL full_pop_gnt: got %b want 00", o_m_gnt); else n_pass++;
        n_total++; if (o_s_rdy !== 1'b1) $display("FAIL full_pop_rdy: got %b want 1", o_s_rdy); else n_pass++;
        tick();
        i_s_rsp = 1'b0;
        #1;
        n_total++; if (o_s_req !== 1'b1) $display("FAIL full_reassert: got %b want 1", o_s_req); else n_pass++;
        n_total++; if (o_m_gnt !== 2'b01) $display("FAIL full_regnt: got %b want 01", o_m_gnt); else n_pass++;
        for (int c = 0; c < 2; c++) begin
            tick();
            idle_inputs();
            i_s_rsp = 1'b1;
            i_m_rdy = 2'b11;
        end
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL full_cnt0: got %0d want 0", dut.fifo_cnt); else n_pass++;
    endtask

    task automatic test_order_bp();
        tick();
        i_m_addr = {32'h600, 32'h500};
        i_m_req  = 2'b01;
        i_s_gnt  = 1'b1;
        #1;
        n_total++; if (o_m_gnt !== 2'b01) $display("FAIL ord_gnt0: got %b want 01", o_m_gnt); else n_pass++;
        tick();
        i_m_req = 2'b10;
        #1;
        n_total++; if (o_m_gnt !== 2'b10) $display("FAIL ord_gnt1: got %b want 10", o_m_gnt); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            idle_inputs();
            i_s_rsp   = 1'b1;
            i_s_rdata = 32'hA5A5_0000;
            i_m_rdy   = 2'b10;
            #1;
            n_total++; if (o_s_rdy !== 1'b0) $display("FAIL ord_bp_rdy%0d: got %b want 0", c, o_s_rdy); else n_pass++;
            n_total++; if (o_m_rsp[1] !== 1'b0) $display("FAIL ord_bp_m1rsp%0d: got %b want 0", c, o_m_rsp[1]); else n_pass++;
        end
        tick();
        i_m_rdy = 2'b11;
        #1;
        n_total++; if (o_s_rdy !== 1'b1) $display("FAIL ord_rdy: got %b want 1", o_s_rdy); else n_pass++;
        n_total++; if (o_m_rsp !== 2'b01) $display("FAIL ord_rsp_m0: got %b want 01", o_m_rsp); else n_pass++;
        n_total++; if (o_m_rdata[0 +: DW] !== 32'hA5A5_0000) $display("FAIL ord_rdata: got %h want a5a50000", o_m_rdata[0 +: DW]); else n_pass++;
        tick();
        i_s_rdata = 32'h5A5A_0001;
        #1;
        n_total++; if (o_m_rsp !== 2'b10) $display("FAIL ord_rsp_m1: got %b want 10", o_m_rsp); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL ord_cnt0: got %0d want 0", dut.fifo_cnt); else n_pass++;
    endtask

    task automatic test_unexp_rsp();
        tick();
        i_s_rsp = 1'b1;
        i_m_rdy = 2'b11;
        #1;
        n_total++; if (o_s_rdy !== 1'b0) $display("FAIL unexp_rdy: got %b want 0", o_s_rdy); else n_pass++;
        n_total++; if (o_m_rsp !== 2'b00) $display("FAIL unexp_rsp: got %b want 00", o_m_rsp); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++; if (o_err_unexp_rsp !== 1'b1) $display("FAIL unexp_err_set: got %b want 1", o_err_unexp_rsp); else n_pass++;
        tick();
        tick();
        n_total++; if (o_err_unexp_rsp !== 1'b1) $display("FAIL unexp_err_sticky: got %b want 1", o_err_unexp_rsp); else n_pass++;
        i_m_req = 2'b01;
        i_s_gnt = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd1) $display("FAIL unexp_cnt1: got %0d want 1", dut.fifo_cnt); else n_pass++;
        i_rstn = 1'b0;
        #1;
        n_total++; if (dut.fifo_cnt !== 2'd0) $display("FAIL midrst_cnt: got %0d want 0", dut.fifo_cnt); else n_pass++;
        n_total++; if (o_err_unexp_rsp !== 1'b0) $display("FAIL midrst_err: got %b want 0", o_err_unexp_rsp); else n_pass++;
        tick();
        i_rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_full();
        test_order_bp();
        test_unexp_rsp();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
